// File: rtl/adder_pkg.sv
// Shared definitions for the adder result stage: data width and the
// entry-count state encoding of the two-entry result buffer.
package adder_pkg;

  localparam int ADD_WIDTH = 16;

  // Encoding 2'd3 is unused and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry result buffer with registered ready/valid. The head entry drives
// the outputs directly, so there is no combinational path from in_* to out_*.
import adder_pkg::*;

module result_fifo2 #(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  fifo_state_t      state_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] head_data_reg;
  logic             head_carry_reg;
  logic [WIDTH-1:0] tail_data_reg;
  logic             tail_carry_reg;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= EMPTY;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      head_data_reg  <= '0;
      head_carry_reg <= 1'b0;
      tail_data_reg  <= '0;
      tail_carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_data_reg  <= in_data;
            head_carry_reg <= in_carry;
            out_valid_reg  <= 1'b1;
            state_reg      <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_data_reg  <= in_data;
            head_carry_reg <= in_carry;
          end else if (push) begin
            tail_data_reg  <= in_data;
            tail_carry_reg <= in_carry;
            in_ready_reg   <= 1'b0;
            state_reg      <= FULL;
          end else if (pop) begin
            // Head keeps the popped value while empty.
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_data_reg  <= tail_data_reg;
            head_carry_reg <= tail_carry_reg;
            in_ready_reg   <= 1'b1;
            state_reg      <= ONE;
          end
        end
        default: begin
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          state_reg     <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = head_data_reg;
  assign out_carry = head_carry_reg;

endmodule

// File: rtl/adder_result_stage.sv
// Registered output stage behind the 16-bit adder: buffers {cout,sum} in a
// two-entry FIFO. Define ADDER_CARRY_CNT_EN to enable the saturating carry counter.
import adder_pkg::*;

module adder_result_stage #(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic [CNT_W-1:0] carry_count
);

  logic in_ready_int;

  result_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready_int),
    .in_data  (sum),
    .in_carry (cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_carry(out_carry)
  );

  assign in_ready = in_ready_int;

`ifdef ADDER_CARRY_CNT_EN
  logic [CNT_W-1:0] carry_count_reg;

  // Saturates at all-ones; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_count_reg <= '0;
    end else if (in_valid && in_ready_int && cout && (carry_count_reg != {CNT_W{1'b1}})) begin
      carry_count_reg <= carry_count_reg + CNT_W'(1);
    end
  end

  assign carry_count = carry_count_reg;
`else
  assign carry_count = '0;
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: scoreboard queue plus a
// table of hand-derived ready/valid vectors and directed corner sequences.
module tb_adder_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] sum = '0;
  logic        cout = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_carry;
  logic [7:0]  carry_count;

  adder_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .cout       (cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carry  (out_carry),
    .carry_count(carry_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        carry;
  } entry_t;

  typedef struct {
    logic        v;
    logic [15:0] s;
    logic        c;
    logic        r;
    logic        exp_valid;
    logic        exp_ready;
  } vec_t;

  entry_t      q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [15:0] last_data = '0;
  logic        last_carry = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: check outputs at the negedge, drive inputs, update the model.
  task automatic cycle(input logic v, input logic [15:0] s, input logic c, input logic r,
                       input bit use_exp, input logic ev, input logic er);
    bit     can_push;
    entry_t e;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("carry_count", 32'(carry_count), 32'(exp_cnt));
    if (use_exp) begin
      chk("vec_out_valid", 32'(out_valid), 32'(ev));
      chk("vec_in_ready", 32'(in_ready), 32'(er));
    end
    if (q.size() > 0) begin
      chk("head_data", 32'(out_data), 32'(q[0].data));
      chk("head_carry", 32'(out_carry), 32'(q[0].carry));
    end else begin
      chk("idle_data", 32'(out_data), 32'(last_data));
      chk("idle_carry", 32'(out_carry), 32'(last_carry));
    end
    in_valid  = v;
    sum       = s;
    cout      = c;
    out_ready = r;
    can_push  = (q.size() < 2);
    if (r && q.size() > 0) begin
      e = q.pop_front();
      last_data  = e.data;
      last_carry = e.carry;
      $display("POP  data=%04h carry=%0b", e.data, e.carry);
    end
    if (v && can_push) begin
      q.push_back('{data: s, carry: c});
`ifdef ADDER_CARRY_CNT_EN
      if (c && exp_cnt < 255) exp_cnt++;
`endif
      $display("PUSH data=%04h carry=%0b", s, c);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] s, input logic c, input logic r);
    cycle(v, s, c, r, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset with handshakes active on both sides; all of it must be discarded.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; sum = 16'h5A5A; cout = 1'b1; out_ready = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    exp_cnt = 0; last_data = '0; last_carry = 1'b0;
    $display("RESET %0d cycles", n);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 16'h5678, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 16'h9ABC, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'hDEF0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset held two cycles with in_valid high.
    do_reset(2);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_carry_count", 32'(carry_count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // Single pass.
    step(1'b1, 16'hFF00, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Backpressure: third push is ignored while full.
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0);
    step(1'b1, 16'h0003, 1'b0, 1'b0);
    step(1'b1, 16'h0003, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bp_no_0003", 32'(last_data), 32'h0002);

    // Simultaneous push and pop in ONE.
    step(1'b1, 16'h00AA, 1'b0, 1'b0);
    step(1'b1, 16'h00BB, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("simul_head", 32'(out_data), 32'h00BB);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Table vectors from a clean state.
    do_reset(1);
    foreach (vecs[i])
      cycle(vecs[i].v, vecs[i].s, vecs[i].c, vecs[i].r, 1'b1, vecs[i].exp_valid, vecs[i].exp_ready);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Saturation: 300 carry pushes streamed through.
    for (int i = 0; i < 300; i++)
      step(1'b1, 16'(i), 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef ADDER_CARRY_CNT_EN
    chk("sat_count", 32'(carry_count), 32'hFF);
`else
    chk("sat_count_off", 32'(carry_count), 32'h0);
`endif

    // Mid-operation reset from FULL.
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    do_reset(1);
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 16'h3333, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("mid_rst_pop", 32'(last_data), 32'h3333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
